// File: rtl/inst_loop_nest_ctrl.sv
// N-deep nested hardware loop controller with a start/run/done sequencer.
// Optional macro INST_LOOP_HVDIM_EXT_EN enables the dimension-extend increment strobe.
module inst_loop_nest_ctrl #(
  parameter int unsigned InstMemAddrWidth   = 32,
  parameter int unsigned InstLoopCountWidth = 16,
  parameter int unsigned NumLoops           = 4,
  parameter int unsigned DepthWidth         = $clog2(NumLoops + 1),
  parameter int unsigned LoopIdxWidth       = (NumLoops > 1) ? $clog2(NumLoops) : 1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   clr_i,
  input  logic                                   start_i,
  input  logic                                   en_i,
  input  logic                                   stall_i,
  input  logic                                   dbg_en_i,
  input  logic [InstMemAddrWidth-1:0]            inst_pc_i,
  input  logic [DepthWidth-1:0]                  loop_depth_i,
  input  logic [NumLoops*InstMemAddrWidth-1:0]   jump_addr_i,
  input  logic [NumLoops*InstMemAddrWidth-1:0]   end_addr_i,
  input  logic [NumLoops*InstLoopCountWidth-1:0] trip_count_i,
  input  logic                                   hvdim_extend_en_i,
  input  logic [LoopIdxWidth-1:0]                hvdim_sel_i,
  output logic                                   inst_jump_o,
  output logic [InstMemAddrWidth-1:0]            inst_jump_addr_o,
  output logic [NumLoops*InstLoopCountWidth-1:0] loop_count_o,
  output logic                                   busy_o,
  output logic                                   loop_done_o,
  output logic                                   hvdim_extend_inc_o
);

  localparam int unsigned AW = InstMemAddrWidth;
  localparam int unsigned CW = InstLoopCountWidth;
  localparam logic [CW:0] CntOne = (CW + 1)'(1);

  // state_q is the observation point for the sequencer state.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q [NumLoops];
  logic [CW-1:0]   cnt_d [NumLoops];
  logic            done_q, done_d;

  logic [AW-1:0]   end_addr  [NumLoops];
  logic [AW-1:0]   jump_addr [NumLoops];
  logic [CW-1:0]   trip_cnt  [NumLoops];
  logic [NumLoops-1:0] act, hit, bound, take;

  logic [DepthWidth-1:0]   depth;
  logic [LoopIdxWidth-1:0] j_idx;
  logic                    any_take;
  logic                    last_hit;
  logic                    advance;

  always_comb begin
    depth = loop_depth_i;
    if (loop_depth_i > DepthWidth'(NumLoops)) depth = DepthWidth'(NumLoops);
  end

  // Counters are widened by one bit so cnt+1 cannot wrap; trip 0 behaves as 1.
  for (genvar k = 0; k < NumLoops; k++) begin : g_loop
    assign end_addr[k]  = end_addr_i[k*AW +: AW];
    assign jump_addr[k] = jump_addr_i[k*AW +: AW];
    assign trip_cnt[k]  = trip_count_i[k*CW +: CW];
    assign act[k]       = DepthWidth'(k) < depth;
    assign hit[k]       = act[k] && (inst_pc_i == end_addr[k]);
    assign bound[k]     = ({1'b0, cnt_q[k]} + CntOne) >= {1'b0, trip_cnt[k]};
    assign take[k]      = hit[k] & ~bound[k];
    assign loop_count_o[k*CW +: CW] = cnt_q[k];
  end

  // Innermost (lowest index) taking loop wins.
  always_comb begin
    any_take = 1'b0;
    j_idx    = '0;
    for (int k = NumLoops - 1; k >= 0; k--) begin
      if (take[k]) begin
        any_take = 1'b1;
        j_idx    = LoopIdxWidth'(k);
      end
    end
  end

  always_comb begin
    last_hit = 1'b0;
    for (int k = 0; k < NumLoops; k++) begin
      if (depth == DepthWidth'(k + 1)) last_hit = hit[k];
    end
  end

  assign busy_o  = (state_q == ST_RUN);
  assign advance = busy_o & en_i & ~stall_i & ~dbg_en_i;

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    if (clr_i) begin
      state_d = ST_IDLE;
      for (int k = 0; k < NumLoops; k++) cnt_d[k] = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_i) begin
            if (depth == '0) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_RUN;
              for (int k = 0; k < NumLoops; k++) cnt_d[k] = '0;
            end
          end
        end
        ST_RUN: begin
          if (advance) begin
            for (int k = 0; k < NumLoops; k++) begin
              if (!act[k]) begin
                cnt_d[k] = '0;
              end else if (hit[k]) begin
                if (any_take && (LoopIdxWidth'(k) == j_idx)) begin
                  cnt_d[k] = cnt_q[k] + CW'(1);
                end else if (!any_take || (LoopIdxWidth'(k) < j_idx)) begin
                  cnt_d[k] = '0;
                end
              end
            end
            if (!any_take && last_hit) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
      for (int k = 0; k < NumLoops; k++) cnt_q[k] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      for (int k = 0; k < NumLoops; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  assign inst_jump_o      = busy_o & any_take;
  assign inst_jump_addr_o = inst_jump_o ? jump_addr[j_idx] : '0;
  assign loop_done_o      = done_q;

`ifdef INST_LOOP_HVDIM_EXT_EN
  logic hv_hit;
  always_comb begin
    hv_hit = 1'b0;
    for (int k = 0; k < NumLoops; k++) begin
      if (hvdim_sel_i == LoopIdxWidth'(k)) hv_hit = hit[k];
    end
  end
  assign hvdim_extend_inc_o = busy_o & hvdim_extend_en_i & hv_hit;
`else
  logic unused_hvdim;
  assign unused_hvdim       = ^{hvdim_extend_en_i, hvdim_sel_i};
  assign hvdim_extend_inc_o = 1'b0;
`endif

endmodule

// File: tb/tb_inst_loop_nest_ctrl.sv
// Self-checking bench for inst_loop_nest_ctrl: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a loop-nest model.
`timescale 1ns/1ps
module tb_inst_loop_nest_ctrl;

  localparam int AW = 8;
  localparam int CW = 8;
  localparam int NL = 4;
  localparam int DW = $clog2(NL + 1);
  localparam int LW = $clog2(NL);

  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              clr, start, en, stall, dbg_en;
  logic [AW-1:0]     inst_pc;
  logic [DW-1:0]     loop_depth;
  logic [NL*AW-1:0]  jump_addr, end_addr;
  logic [NL*CW-1:0]  trip_count;
  logic              hv_en;
  logic [LW-1:0]     hv_sel;
  logic              inst_jump;
  logic [AW-1:0]     inst_jump_addr;
  logic [NL*CW-1:0]  loop_count;
  logic              busy, loop_done, hv_inc;

  inst_loop_nest_ctrl #(
    .InstMemAddrWidth(AW), .InstLoopCountWidth(CW), .NumLoops(NL)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .start_i(start),
    .en_i(en), .stall_i(stall), .dbg_en_i(dbg_en),
    .inst_pc_i(inst_pc), .loop_depth_i(loop_depth),
    .jump_addr_i(jump_addr), .end_addr_i(end_addr), .trip_count_i(trip_count),
    .hvdim_extend_en_i(hv_en), .hvdim_sel_i(hv_sel),
    .inst_jump_o(inst_jump), .inst_jump_addr_o(inst_jump_addr),
    .loop_count_o(loop_count), .busy_o(busy), .loop_done_o(loop_done),
    .hvdim_extend_inc_o(hv_inc)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int done_seen = 0;
  logic [AW-1:0] exp_q[$];
  logic [AW-1:0] got_q[$];
  logic [2*CW-1:0] trace_q[$];
  logic [2*CW-1:0] trace_exp_q[$];
  logic [AW-1:0] trace_pc;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_state;
  int m_cnt [NL];
  bit m_done;

  function automatic int f_depth();
    return (int'(loop_depth) > NL) ? NL : int'(loop_depth);
  endfunction
  function automatic int f_end(input int k);
    return int'(end_addr[k*AW +: AW]);
  endfunction
  function automatic int f_jump(input int k);
    return int'(jump_addr[k*AW +: AW]);
  endfunction
  function automatic int f_trip(input int k);
    return int'(trip_count[k*CW +: CW]);
  endfunction
  function automatic bit f_hit(input int k);
    return (k < f_depth()) && (int'(inst_pc) == f_end(k));
  endfunction
  // Innermost loop that still has iterations to go at the current PC, or -1.
  function automatic int f_jump_loop();
    for (int k = 0; k < NL; k++)
      if (f_hit(k) && (m_cnt[k] + 1 < f_trip(k))) return k;
    return -1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = S_IDLE;
      m_done  = 0;
      for (int k = 0; k < NL; k++) m_cnt[k] = 0;
    end else if (clr) begin
      m_state = S_IDLE;
      m_done  = 0;
      for (int k = 0; k < NL; k++) m_cnt[k] = 0;
    end else begin
      m_done = 0;
      if (m_state != S_RUN) begin
        if (start) begin
          if (f_depth() == 0) begin
            m_state = S_DONE;
            m_done  = 1;
          end else begin
            m_state = S_RUN;
            for (int k = 0; k < NL; k++) m_cnt[k] = 0;
          end
        end
      end else if (en && !stall && !dbg_en) begin
        int jl;
        bit last;
        jl   = f_jump_loop();
        last = (f_depth() > 0) && f_hit(f_depth() - 1);
        for (int k = 0; k < NL; k++) begin
          if (k >= f_depth()) m_cnt[k] = 0;
          else if (f_hit(k)) begin
            if (k == jl) m_cnt[k] = m_cnt[k] + 1;
            else if (jl < 0 || k < jl) m_cnt[k] = 0;
          end
        end
        if (jl < 0 && last) begin
          m_state = S_DONE;
          m_done  = 1;
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    int jl;
    bit e_busy, e_jump, e_hv;
    int e_addr;
    #2;
    jl     = f_jump_loop();
    e_busy = (m_state == S_RUN);
    e_jump = e_busy && (jl >= 0);
    e_addr = e_jump ? f_jump(jl) : 0;
`ifdef INST_LOOP_HVDIM_EXT_EN
    e_hv = e_busy && hv_en && (int'(hv_sel) < f_depth()) && (int'(inst_pc) == f_end(int'(hv_sel)));
`else
    e_hv = 0;
`endif
    check("busy", busy, e_busy);
    check("done", loop_done, m_done);
    check("jump", inst_jump, e_jump);
    check("jump_addr", inst_jump_addr, e_addr);
    check("hv_inc", hv_inc, e_hv);
    for (int k = 0; k < NL; k++)
      check($sformatf("cnt%0d", k), loop_count[k*CW +: CW], m_cnt[k]);
    if (loop_done === 1'b1) done_seen++;
  end

  // ---------------- driver tasks ----------------
  task automatic set_loop(input int k, input int e, input int j, input int t);
    end_addr[k*AW +: AW]   = AW'(e);
    jump_addr[k*AW +: AW]  = AW'(j);
    trip_count[k*CW +: CW] = CW'(t);
  endtask

  task automatic clear_cfg();
    for (int k = 0; k < NL; k++) set_loop(k, 8'hE0 + k, 0, 0);
  endtask

  task automatic do_start();
    @(negedge clk);
    inst_pc = 8'hF0;
    start = 1;
    @(negedge clk);
    start = 0;
  endtask

  task automatic do_clr();
    @(negedge clk);
    clr = 1;
    @(negedge clk);
    clr = 0;
  endtask

  // Walk the PC from 0, following taken jumps, until the done pulse appears.
  task automatic walk(input int budget);
    int pc;
    bit seen;
    pc = 0;
    seen = 0;
    got_q.delete();
    trace_q.delete();
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      inst_pc = AW'(pc);
      #1;
      if (AW'(pc) == trace_pc) trace_q.push_back(loop_count[2*CW-1:0]);
      if (loop_done === 1'b1) seen = 1;
      else if (inst_jump === 1'b1) begin
        got_q.push_back(inst_jump_addr);
        pc = int'(inst_jump_addr);
      end else pc = pc + 1;
    end
    check("walk_reaches_done", seen, 1'b1);
    inst_pc = 8'hF0;
  endtask

  task automatic compare_jumps(input string name);
    check({name, "_njumps"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_jump%0d", name, i), got_q[i], exp_q[i]);
    check({name, "_ntrace"}, trace_q.size(), trace_exp_q.size());
    for (int i = 0; i < trace_exp_q.size() && i < trace_q.size(); i++)
      check($sformatf("%s_trace%0d", name, i), trace_q[i], trace_exp_q[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int d0;
    clr = 0; start = 0; en = 1; stall = 0; dbg_en = 0;
    inst_pc = 8'hF0; loop_depth = '0; hv_en = 0; hv_sel = '0;
    jump_addr = '0; end_addr = '0; trip_count = '0;
    clear_cfg();
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", loop_done, 1'b0);
    check("rst_cnt", loop_count, '0);
    check("rst_jump", inst_jump, 1'b0);
    @(negedge clk);
    rst_n = 1;

    // Single loop: jumps to 2 twice, then done.
    clear_cfg();
    loop_depth = 1;
    set_loop(0, 5, 2, 3);
    trace_pc = 5;
    do_start();
    d0 = done_seen;
    walk(60);
    repeat (3) @(negedge clk);
    exp_q = '{8'd2, 8'd2};
    trace_exp_q = '{16'h0000, 16'h0001, 16'h0002};
    compare_jumps("single");
    check("single_done_pulses", done_seen - d0, 1);
    check("single_idle_after", busy, 1'b0);

    // Shared end address: inner advances, outer steps only when inner is at bound.
    clear_cfg();
    loop_depth = 2;
    set_loop(0, 8, 4, 2);
    set_loop(1, 8, 1, 3);
    trace_pc = 8;
    do_start();
    d0 = done_seen;
    walk(120);
    repeat (2) @(negedge clk);
    exp_q = '{8'd4, 8'd1, 8'd4, 8'd1, 8'd4};
    trace_exp_q = '{16'h0000, 16'h0001, 16'h0100, 16'h0101, 16'h0200, 16'h0201};
    compare_jumps("shared");
    check("shared_done_pulses", done_seen - d0, 1);

    // Zero trip count: no jump, immediate completion.
    clear_cfg();
    loop_depth = 1;
    set_loop(0, 3, 1, 0);
    trace_pc = 3;
    do_start();
    d0 = done_seen;
    walk(20);
    repeat (2) @(negedge clk);
    exp_q.delete();
    trace_exp_q = '{16'h0000};
    compare_jumps("zero_trip");
    check("zero_done_pulses", done_seen - d0, 1);
    check("zero_cnt", loop_count[CW-1:0], 0);

    // Zero-depth start goes straight to done.
    loop_depth = 0;
    d0 = done_seen;
    do_start();
    @(negedge clk);
    check("depth0_done_pulses", done_seen - d0, 1);
    check("depth0_busy", busy, 1'b0);

    // Stall / debug freeze.
    clear_cfg();
    loop_depth = 1;
    set_loop(0, 5, 2, 3);
    do_start();
    @(negedge clk);
    inst_pc = 5; stall = 1;
    #1;
    check("stall_jump", inst_jump, 1'b1);
    check("stall_jump_addr", inst_jump_addr, 8'd2);
    repeat (2) @(negedge clk);
    #1;
    check("stall_cnt_frozen", loop_count[CW-1:0], 0);
    @(negedge clk);
    stall = 0;
    @(negedge clk);
    inst_pc = 0;
    #1;
    check("stall_release_cnt", loop_count[CW-1:0], 1);
    @(negedge clk);
    inst_pc = 5; dbg_en = 1;
    repeat (2) @(negedge clk);
    dbg_en = 0; inst_pc = 0;
    #1;
    check("dbg_cnt_frozen", loop_count[CW-1:0], 1);
    do_clr();

    // clr and async reset mid-run.
    clear_cfg();
    loop_depth = 2;
    set_loop(0, 10, 0, 5);
    set_loop(1, 20, 0, 5);
    do_start();
    @(negedge clk); inst_pc = 10;
    @(negedge clk); inst_pc = 10;
    @(negedge clk); inst_pc = 20;
    @(negedge clk); inst_pc = 0;
    #1;
    check("clr_pre_cnt", loop_count[2*CW-1:0], 16'h0102);
    clr = 1;
    d0 = done_seen;
    @(negedge clk);
    clr = 0;
    #1;
    check("clr_busy", busy, 1'b0);
    check("clr_cnt", loop_count, '0);
    check("clr_no_done", done_seen - d0, 0);
    do_start();
    @(negedge clk); inst_pc = 10;
    @(negedge clk); inst_pc = 0;
    #3;
    rst_n = 0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_cnt", loop_count, '0);
    check("arst_done", loop_done, 1'b0);
    @(negedge clk);
    rst_n = 1;

    // Dimension-extend strobe.
    clear_cfg();
    loop_depth = 2;
    set_loop(0, 10, 0, 9);
    set_loop(1, 20, 0, 9);
    set_loop(3, 30, 0, 9);
    hv_en = 1; hv_sel = 1;
    do_start();
    @(negedge clk); inst_pc = 20;
    #1;
`ifdef INST_LOOP_HVDIM_EXT_EN
    check("hv_on_hit", hv_inc, 1'b1);
`else
    check("hv_off_hit", hv_inc, 1'b0);
`endif
    @(negedge clk); inst_pc = 10;
    #1;
    check("hv_other_loop", hv_inc, 1'b0);
    @(negedge clk); hv_sel = 3; inst_pc = 30;
    #1;
    check("hv_sel_beyond_depth", hv_inc, 1'b0);
    hv_en = 0;
    do_clr();

    // Randomized traffic, checked every cycle by the model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (c % 64 == 0) begin
        for (int k = 0; k < NL; k++)
          set_loop(k, $urandom_range(4, 15), $urandom_range(0, 3), $urandom_range(0, 3));
        loop_depth = DW'($urandom_range(0, 6));
      end
      if ($urandom_range(0, 199) == 0) loop_depth = DW'($urandom_range(0, 7));
      inst_pc = AW'($urandom_range(0, 15));
      start   = ($urandom_range(0, 9) == 0);
      clr     = ($urandom_range(0, 149) == 0);
      en      = ($urandom_range(0, 9) != 0);
      stall   = ($urandom_range(0, 9) == 0);
      dbg_en  = ($urandom_range(0, 19) == 0);
      hv_en   = $urandom_range(0, 1) == 1;
      hv_sel  = LW'($urandom_range(0, NL - 1));
    end
    @(negedge clk);
    start = 0; clr = 0;
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
